// File: rtl/booth_mul_scheduler_if.sv
// Bundle between the multiplier scheduler, its requesters, the shared Booth core
// and the response consumer.
interface booth_mul_scheduler_if #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8,
   parameter int ID_W  = $clog2(N_REQ)
);
   // Handshakes: a transfer happens on a rising clk edge where valid and ready are
   // both 1; valid never waits on ready, and the payload is held while valid is up.
   logic [N_REQ-1:0]       req_valid;
   logic [N_REQ*WIDTH-1:0] req_a;
   logic [N_REQ*WIDTH-1:0] req_b;
   logic [N_REQ-1:0]       req_ready;
   logic                   mul_start;
   logic [WIDTH-1:0]       mul_a;
   logic [WIDTH-1:0]       mul_b;
   logic                   mul_done;
   logic [2*WIDTH-1:0]     mul_p;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [ID_W-1:0]        rsp_id;
   logic [2*WIDTH-1:0]     rsp_p;
   logic                   rsp_err;
   logic                   busy;
   logic [1:0]             state_dbg;

   modport master (
      input  req_valid, req_a, req_b, mul_done, mul_p, rsp_ready,
      output req_ready, mul_start, mul_a, mul_b, rsp_valid, rsp_id, rsp_p, rsp_err,
             busy, state_dbg
   );

   modport slave (
      output req_valid, req_a, req_b, mul_done, mul_p, rsp_ready,
      input  req_ready, mul_start, mul_a, mul_b, rsp_valid, rsp_id, rsp_p, rsp_err,
             busy, state_dbg
   );
endinterface

// File: rtl/booth_mul_scheduler.sv
// Round-robin arbiter that shares one sequential Booth multiplier core among
// N_REQ requesters, with a done watchdog and a single tagged response channel.
module booth_mul_scheduler #(
   parameter int N_REQ   = 4,
   parameter int WIDTH   = 8,
   parameter int TIMEOUT = 64
) (
   input logic                 clk,
   input logic                 rst_n,
   booth_mul_scheduler_if.master bus
);

   localparam int ID_W = $clog2(N_REQ);
   localparam int TW   = $clog2(TIMEOUT);
   localparam int PW   = 2 * WIDTH;

   localparam logic [ID_W:0]   N_REQ_W      = (ID_W + 1)'(N_REQ);
   localparam logic [ID_W-1:0] LAST_ID      = ID_W'(N_REQ - 1);
   localparam logic [TW-1:0]   TIMEOUT_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [ID_W-1:0]   rr_ptr;
   logic [ID_W-1:0]   gnt_id;
   logic [ID_W-1:0]   next_ptr;
   logic [ID_W-1:0]   pick;
   logic [ID_W-1:0]   idx;
   logic [ID_W:0]     sum;
   logic              pick_ok;
   logic [WIDTH-1:0]  a_arr [N_REQ];
   logic [WIDTH-1:0]  b_arr [N_REQ];
   logic [WIDTH-1:0]  a_q;
   logic [WIDTH-1:0]  b_q;
   logic [TW-1:0]     timer;
   logic [PW-1:0]     p_q;
   logic              err_q;
   logic              busy_q;
   logic [N_REQ-1:0]  ready_c;
   logic              accept;
   logic              rsp_fire;
   logic              timeout_hit;

   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         a_arr[i] = bus.req_a[i*WIDTH +: WIDTH];
         b_arr[i] = bus.req_b[i*WIDTH +: WIDTH];
      end
   end

   // Rotating priority search starting at rr_ptr; sum stays below 2*N_REQ so one
   // conditional subtract is enough to wrap it.
   always_comb begin
      pick    = '0;
      pick_ok = 1'b0;
      sum     = '0;
      idx     = '0;
      for (int k = 0; k < N_REQ; k++) begin
         sum = {1'b0, rr_ptr} + (ID_W + 1)'(k);
         if (sum >= N_REQ_W) begin
            sum = sum - N_REQ_W;
         end
         idx = sum[ID_W-1:0];
         if (!pick_ok && bus.req_valid[idx]) begin
            pick_ok = 1'b1;
            pick    = idx;
         end
      end
   end

   assign timeout_hit = (timer == TIMEOUT_LAST);
   assign next_ptr    = (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;

   always_comb begin
      state_nxt = state;
      ready_c   = '0;
      accept    = 1'b0;
      rsp_fire  = 1'b0;
      case (state)
         IDLE: begin
            if (pick_ok) begin
               ready_c[pick] = 1'b1;
               accept        = 1'b1;
               state_nxt     = ISSUE;
            end
         end
         ISSUE: state_nxt = WAIT;
         WAIT: begin
            if (bus.mul_done || timeout_hit) begin
               state_nxt = RESP;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               rsp_fire  = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         rr_ptr <= '0;
         gnt_id <= '0;
         a_q    <= '0;
         b_q    <= '0;
         timer  <= '0;
         p_q    <= '0;
         err_q  <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         busy_q <= (state_nxt != IDLE);
         if (accept) begin
            gnt_id <= pick;
            a_q    <= a_arr[pick];
            b_q    <= b_arr[pick];
         end
         if (state == ISSUE) begin
            timer <= '0;
         end else if (state == WAIT && !bus.mul_done && !timeout_hit) begin
            timer <= timer + 1'b1;
         end
         // A done landing on the last watchdog cycle still counts as success.
         if (state == WAIT) begin
            if (bus.mul_done) begin
               p_q   <= bus.mul_p;
               err_q <= 1'b0;
            end else if (timeout_hit) begin
               p_q   <= '0;
               err_q <= 1'b1;
            end
         end
         if (rsp_fire) begin
            rr_ptr <= next_ptr;
         end
      end
   end

   // The accept strobe is combinational, so it is gated to stay low while in reset.
   assign bus.req_ready = ready_c & {N_REQ{rst_n}};
   assign bus.mul_start = (state == ISSUE);
   assign bus.mul_a     = a_q;
   assign bus.mul_b     = b_q;
   assign bus.rsp_valid = (state == RESP);
   assign bus.rsp_id    = gnt_id;
   assign bus.rsp_p     = p_q;
   assign bus.rsp_err   = err_q;
   assign bus.busy      = busy_q;
   assign bus.state_dbg = state;

   a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(bus.req_ready));

   a_start_pulse: assert property (@(posedge clk) disable iff (!rst_n)
      bus.mul_start |=> !bus.mul_start);

   a_rsp_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (bus.rsp_valid && !bus.rsp_ready) |=>
         (bus.rsp_valid && $stable({bus.rsp_id, bus.rsp_p, bus.rsp_err})));

endmodule
